// File: rtl/rshift_round_sat_if.sv
// Stream bundle for rshift_round_sat: input beat (data, shift amount, round
// mode) with valid/ready, output beat (data, saturation flag) with
// valid/ready, and the saturated-beat counter.
//   master : upstream/downstream side (drives in_*, out_ready)
//   slave  : the shifter itself
interface rshift_round_sat_if #(
  parameter int WIDTH_IN      = 16,
  parameter int WIDTH_OUT     = 16,
  parameter int ELEMENTS      = 32,
  parameter int TOTAL_INPUT_W = 2,
  parameter int SHIFT_W       = 4,
  parameter int CNT_W         = 16
);
  logic                                           in_valid;
  logic                                           in_ready;
  logic [TOTAL_INPUT_W-1:0][WIDTH_IN*ELEMENTS-1:0]  in_data;
  logic [SHIFT_W-1:0]                             in_shamt;
  logic                                           in_round;
  logic                                           out_valid;
  logic                                           out_ready;
  logic [TOTAL_INPUT_W-1:0][WIDTH_OUT*ELEMENTS-1:0] out_data;
  logic                                           out_sat;
  logic [CNT_W-1:0]                               sat_beats;

  modport master (
    output in_valid, in_data, in_shamt, in_round, out_ready,
    input  in_ready, out_valid, out_data, out_sat, sat_beats
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_round, out_ready,
    output in_ready, out_valid, out_data, out_sat, sat_beats
  );
endinterface

// File: rtl/rshift_round_sat.sv
// Arithmetic right shifter for packed signed fixed-point vectors, with
// per-beat shift amount and truncate/round-half-up mode, optional narrowing
// to WIDTH_OUT with saturation, and a 2-stage valid/ready pipeline.
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : rshift_round_sat_if.slave
//          in_valid/in_ready/in_data/in_shamt/in_round   input beat
//          out_valid/out_ready/out_data/out_sat          output beat
//          sat_beats   accepted output beats with out_sat=1 (sticks at all-ones)
// Element e of vector w sits at bits [ELEMENTS*W-1-e*W -: W] (element 0 at MSBs).
module rshift_round_sat #(
  parameter int WIDTH_IN      = 16,
  parameter int WIDTH_OUT     = 16,
  parameter int ELEMENTS      = 32,
  parameter int TOTAL_INPUT_W = 2,
  parameter int SHIFT_W       = 4,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  rshift_round_sat_if.slave bus
);

  // Clamp limits expressed in the (WIDTH_IN+1)-bit stage-1 domain.
  localparam logic signed [WIDTH_IN:0] SAT_MAX =
    {{(WIDTH_IN-WIDTH_OUT+2){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
  localparam logic signed [WIDTH_IN:0] SAT_MIN =
    {{(WIDTH_IN-WIDTH_OUT+2){1'b1}}, {(WIDTH_OUT-1){1'b0}}};

  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;

  logic [TOTAL_INPUT_W-1:0][ELEMENTS-1:0][WIDTH_IN:0] s1_y;
  logic [TOTAL_INPUT_W-1:0][ELEMENTS-1:0][WIDTH_IN:0] s1_y_next;

  logic [TOTAL_INPUT_W-1:0][WIDTH_OUT*ELEMENTS-1:0] out_data_q;
  logic [TOTAL_INPUT_W-1:0][WIDTH_OUT*ELEMENTS-1:0] out_data_next;
  logic                                             out_sat_q;
  logic                                             out_sat_next;
  logic [CNT_W-1:0]                                 sat_beats_q;

  // One extra bit of headroom so that adding the rounding bias can never
  // overflow, e.g. max positive + 2^(s-1).
  function automatic logic [WIDTH_IN:0] shift_elem(
    input logic [WIDTH_IN-1:0] x,
    input logic [SHIFT_W-1:0]  s,
    input logic                rnd
  );
    logic        [WIDTH_IN:0] bias;
    logic signed [WIDTH_IN:0] t;
    bias = '0;
    if (rnd && (s != '0))
      bias = (WIDTH_IN+1)'(1) << (s - SHIFT_W'(1));
    t = $signed({x[WIDTH_IN-1], x}) + $signed(bias);
    return t >>> s;
  endfunction

  function automatic logic [WIDTH_OUT-1:0] clamp_elem(
    input  logic signed [WIDTH_IN:0] y,
    output logic                     sat
  );
    sat = 1'b1;
    if (y > SAT_MAX) return SAT_MAX[WIDTH_OUT-1:0];
    if (y < SAT_MIN) return SAT_MIN[WIDTH_OUT-1:0];
    sat = 1'b0;
    return y[WIDTH_OUT-1:0];
  endfunction

  assign s2_adv = !s2_valid || bus.out_ready;
  assign s1_adv = !s1_valid || s2_adv;

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.sat_beats = sat_beats_q;

  always_comb begin
    s1_y_next = '0;
    for (int unsigned w = 0; w < TOTAL_INPUT_W; w++) begin
      for (int unsigned e = 0; e < ELEMENTS; e++) begin
        s1_y_next[w][e] = shift_elem(
          bus.in_data[w][ELEMENTS*WIDTH_IN-1-e*WIDTH_IN -: WIDTH_IN],
          bus.in_shamt, bus.in_round);
      end
    end
  end

  always_comb begin
    logic elem_sat;
    out_data_next = '0;
    out_sat_next  = 1'b0;
    elem_sat      = 1'b0;
    for (int unsigned w = 0; w < TOTAL_INPUT_W; w++) begin
      for (int unsigned e = 0; e < ELEMENTS; e++) begin
        out_data_next[w][ELEMENTS*WIDTH_OUT-1-e*WIDTH_OUT -: WIDTH_OUT] =
          clamp_elem(s1_y[w][e], elem_sat);
        out_sat_next = out_sat_next | elem_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      sat_beats_q <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid)
          s1_y <= s1_y_next;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data_q <= out_data_next;
          out_sat_q  <= out_sat_next;
        end
      end
      if (s2_valid && bus.out_ready && out_sat_q && (sat_beats_q != '1))
        sat_beats_q <= sat_beats_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rshift_round_sat.sv
// Directed bench for rshift_round_sat: a 16->16 instance for shift/round
// arithmetic and backpressure streaming, and a 16->8 instance with a 2-bit
// counter for saturation and counter sticking. Both share clk and rst.
module tb_rshift_round_sat;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rshift_round_sat_if #(.WIDTH_IN(16), .WIDTH_OUT(16), .ELEMENTS(4),
    .TOTAL_INPUT_W(2), .SHIFT_W(4), .CNT_W(16)) if16 ();
  rshift_round_sat_if #(.WIDTH_IN(16), .WIDTH_OUT(8), .ELEMENTS(4),
    .TOTAL_INPUT_W(2), .SHIFT_W(4), .CNT_W(2)) if8 ();

  rshift_round_sat #(.WIDTH_IN(16), .WIDTH_OUT(16), .ELEMENTS(4),
    .TOTAL_INPUT_W(2), .SHIFT_W(4), .CNT_W(16)) u16 (
    .clk(clk), .rst(rst), .bus(if16.slave));
  rshift_round_sat #(.WIDTH_IN(16), .WIDTH_OUT(8), .ELEMENTS(4),
    .TOTAL_INPUT_W(2), .SHIFT_W(4), .CNT_W(2)) u8 (
    .clk(clk), .rst(rst), .bus(if8.slave));

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0][63:0] td [4];
  logic [3:0]       ts [4];
  logic             tr [4];
  logic [1:0][63:0] te [4];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0][63:0] pk16(input logic [15:0] a, b, c, d, e, f, g, h);
    logic [1:0][63:0] r;
    r[0] = {a, b, c, d};
    r[1] = {e, f, g, h};
    return r;
  endfunction

  function automatic logic [1:0][31:0] pk8(input logic [7:0] a, b, c, d, e, f, g, h);
    logic [1:0][31:0] r;
    r[0] = {a, b, c, d};
    r[1] = {e, f, g, h};
    return r;
  endfunction

  // One beat through the 16-bit instance with out_ready=1: checks exact latency.
  task automatic run16(input string tag, input logic [1:0][63:0] d, input logic [3:0] s,
                       input logic r, input logic [1:0][63:0] exp);
    chk({tag, "_in_ready"}, 128'(if16.in_ready), 128'(1));
    if16.in_valid = 1'b1; if16.in_data = d; if16.in_shamt = s; if16.in_round = r;
    tick();
    if16.in_valid = 1'b0; if16.in_data = '1; if16.in_shamt = 4'hF; if16.in_round = ~r;
    chk({tag, "_lat1"}, 128'(if16.out_valid), 128'(0));
    tick();
    chk({tag, "_valid"}, 128'(if16.out_valid), 128'(1));
    chk({tag, "_data"}, 128'(if16.out_data), 128'(exp));
    chk({tag, "_sat"}, 128'(if16.out_sat), 128'(0));
    tick();
    chk({tag, "_gone"}, 128'(if16.out_valid), 128'(0));
  endtask

  task automatic run8(input string tag, input logic [1:0][63:0] d, input logic [3:0] s,
                      input logic r, input logic [1:0][31:0] exp, input logic exp_sat,
                      input logic [1:0] exp_cnt);
    if8.in_valid = 1'b1; if8.in_data = d; if8.in_shamt = s; if8.in_round = r;
    tick();
    if8.in_valid = 1'b0; if8.in_data = '0;
    chk({tag, "_lat1"}, 128'(if8.out_valid), 128'(0));
    tick();
    chk({tag, "_valid"}, 128'(if8.out_valid), 128'(1));
    chk({tag, "_data"}, 128'(if8.out_data), 128'(exp));
    chk({tag, "_sat"}, 128'(if8.out_sat), 128'(exp_sat));
    tick();
    chk({tag, "_cnt"}, 128'(if8.sat_beats), 128'(exp_cnt));
  endtask

  initial begin
    int acc, rcv, occ;
    logic xin, xout;

    td[0] = pk16(16'h0018, 16'hFFE8, 16'h7FFF, 16'h8000, 16'h0000, 16'h0010, 16'hFFFF, 16'h000F);
    ts[0] = 4'd4; tr[0] = 1'b0;
    te[0] = pk16(16'h0001, 16'hFFFE, 16'h07FF, 16'hF800, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000);
    td[1] = td[0]; ts[1] = 4'd4; tr[1] = 1'b1;
    te[1] = pk16(16'h0002, 16'hFFFF, 16'h0800, 16'hF800, 16'h0000, 16'h0001, 16'h0000, 16'h0001);
    td[2] = td[0]; ts[2] = 4'd0; tr[2] = 1'b1;
    te[2] = td[0];
    td[3] = pk16(16'h7FFF, 16'h0001, 16'hFFFF, 16'h8000, 16'h0003, 16'hFFFD, 16'h0002, 16'h0000);
    ts[3] = 4'd1; tr[3] = 1'b1;
    te[3] = pk16(16'h4000, 16'h0001, 16'h0000, 16'hC000, 16'h0002, 16'hFFFF, 16'h0001, 16'h0000);

    rst = 1'b1;
    if16.in_valid = 1'b0; if16.in_data = '0; if16.in_shamt = '0; if16.in_round = 1'b0;
    if16.out_ready = 1'b1;
    if8.in_valid = 1'b0; if8.in_data = '0; if8.in_shamt = '0; if8.in_round = 1'b0;
    if8.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_valid16", 128'(if16.out_valid), 128'(0));
    chk("rst_data16", 128'(if16.out_data), 128'(0));
    chk("rst_ready16", 128'(if16.in_ready), 128'(1));
    chk("rst_valid8", 128'(if8.out_valid), 128'(0));
    chk("rst_cnt8", 128'(if8.sat_beats), 128'(0));
    chk("rst_sat8", 128'(if8.out_sat), 128'(0));

    run16("trunc", td[0], ts[0], tr[0], te[0]);
    run16("round", td[1], ts[1], tr[1], te[1]);
    run16("s0_r1", td[2], ts[2], tr[2], te[2]);
    run16("s0_r0", td[0], 4'd0, 1'b0, td[0]);
    run16("headroom", td[3], ts[3], tr[3], te[3]);

    run8("sat_a", pk16(16'h1000, 16'hF000, 16'h0070, 16'h07F0, 16'hF800, 16'h0800, 16'hFFE8, 16'h0000),
         4'd4, 1'b0, pk8(8'h7F, 8'h80, 8'h07, 8'h7F, 8'h80, 8'h7F, 8'hFE, 8'h00), 1'b1, 2'd1);
    run8("nosat", pk16(16'h0070, 16'h07F0, 16'hF800, 16'hFFE8, 16'h0018, 16'h0000, 16'h0010, 16'hFFFF),
         4'd4, 1'b0, pk8(8'h07, 8'h7F, 8'h80, 8'hFE, 8'h01, 8'h00, 8'h01, 8'hFF), 1'b0, 2'd1);

    // Saturated beat held under backpressure: output and counter must not move.
    if8.out_ready = 1'b0;
    if8.in_valid = 1'b1; if8.in_shamt = 4'd0; if8.in_round = 1'b0;
    if8.in_data = pk16(16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tick();
    if8.in_valid = 1'b0;
    tick(); tick(); tick();
    chk("hold_valid", 128'(if8.out_valid), 128'(1));
    chk("hold_data", 128'(if8.out_data), 128'(pk8(8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00)));
    chk("hold_sat", 128'(if8.out_sat), 128'(1));
    chk("hold_cnt", 128'(if8.sat_beats), 128'(1));
    chk("hold_ready", 128'(if8.in_ready), 128'(1));
    if8.out_ready = 1'b1;
    tick();
    chk("hold_cnt_after", 128'(if8.sat_beats), 128'(2));
    chk("hold_gone", 128'(if8.out_valid), 128'(0));

    run8("round_sat", pk16(16'h07F8, 16'h07F7, 16'hFF78, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000),
         4'd4, 1'b1, pk8(8'h7F, 8'h7F, 8'hF8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b1, 2'd3);
    run8("cnt_stick", pk16(16'h1000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000),
         4'd4, 1'b0, pk8(8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b1, 2'd3);

    // Stream 8 beats with random out_ready; occ tracks beats inside the pipe.
    acc = 0; rcv = 0; occ = 0;
    for (int cyc = 0; cyc < 300 && rcv < 8; cyc++) begin
      if16.out_ready = ($urandom % 2) == 1;
      if16.in_valid  = (acc < 8);
      if16.in_data   = td[acc % 4];
      if16.in_shamt  = ts[acc % 4];
      if16.in_round  = tr[acc % 4];
      #1;
      chk("bp_in_ready", 128'(if16.in_ready), 128'(!(occ == 2 && !if16.out_ready)));
      xout = if16.out_valid && if16.out_ready;
      xin  = if16.in_valid && if16.in_ready;
      if (if16.out_valid) begin
        chk("bp_no_extra", 128'(rcv < acc), 128'(1));
      end
      if (xout && rcv < acc) begin
        chk("bp_data", 128'(if16.out_data), 128'(te[rcv % 4]));
        rcv++;
      end
      if (xin) acc++;
      occ = occ + (xin ? 1 : 0) - (xout ? 1 : 0);
      tick();
    end
    if16.in_valid = 1'b0;
    if16.out_ready = 1'b1;
    chk("bp_count", 128'(rcv), 128'(8));
    tick(); tick();
    chk("bp_drained", 128'(if16.out_valid), 128'(0));

    // Reset with two beats in flight on both instances, and a beat offered in the reset cycle.
    if16.out_ready = 1'b0; if8.out_ready = 1'b0;
    if16.in_valid = 1'b1; if16.in_data = td[0]; if16.in_shamt = 4'd4; if16.in_round = 1'b0;
    if8.in_valid = 1'b1;
    if8.in_data = pk16(16'h1000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    if8.in_shamt = 4'd4; if8.in_round = 1'b0;
    tick(); tick();
    chk("full_ready16", 128'(if16.in_ready), 128'(0));
    chk("full_ready8", 128'(if8.in_ready), 128'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if16.in_valid = 1'b0; if8.in_valid = 1'b0;
    if16.out_ready = 1'b1; if8.out_ready = 1'b1;
    chk("mrst_valid16", 128'(if16.out_valid), 128'(0));
    chk("mrst_valid8", 128'(if8.out_valid), 128'(0));
    chk("mrst_cnt8", 128'(if8.sat_beats), 128'(0));
    chk("mrst_data8", 128'(if8.out_data), 128'(0));
    chk("mrst_ready16", 128'(if16.in_ready), 128'(1));
    tick(); tick();
    chk("mrst_dropped16", 128'(if16.out_valid), 128'(0));
    chk("mrst_dropped8", 128'(if8.out_valid), 128'(0));
    run16("post_rst", td[3], ts[3], tr[3], te[3]);
    run8("post_rst8", pk16(16'hF000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000),
         4'd4, 1'b0, pk8(8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 1'b1, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
